mem_read_controller: RTL and testbench
======================================

# mem_read_controller

Load-side counterpart of the core's store path. It accepts load instructions in the execute stage and selects the addressed memory region. One cycle later it extracts, aligns and sign- or zero-extends the byte, halfword or word from the synchronous-read memory output. It also holds the formatted result stable while the pipeline is stalled. It sits between the execute/memory stage and the writeback mux, alongside the store write controller.

## Interface
- No parameters; opcode and funct3 encodings come from `Opcode.vh` (`OPC_LOAD`, `FNC_LB/LH/LW/LBU/LHU`).
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instruction  in  32  execute-stage instruction; opcode [6:0], funct3 [14:12]
- address  in  32  effective load address, same cycle as instruction
- stall  in  1  pipeline hold; stage state must not advance while high
- dmem_dout  in  32  DMEM read data, valid the cycle after the address is presented
- bios_dout  in  32  BIOS read data, same latency
- io_dout  in  32  memory-mapped I/O read data, same latency
- load_valid  out  1  data_out holds a completed load result
- data_out  out  32  formatted load result for writeback
- misaligned  out  1  completed load was unaligned and was suppressed

## Operation
- Request is accepted when opcode == `OPC_LOAD` and stall == 0.
- On acceptance, the controller captures funct3, address[1:0] and the region, and sets the pending flag.
- Region decode, priority high to low:
  - address[31] → IO
  - address[30] → BIOS
  - address[28] → DMEM
  - otherwise NONE, which reads as 0.
- Extraction uses the captured offset o:
  - LB/LBU: byte dout[8o+7:8o], sign/zero-extended.
  - LH/LHU with o ∈ {0,1,2}: dout[8o+15:8o], sign/zero-extended.
  - LH/LHU with o = 3: result 0 and misaligned = 1. This matches the store side, which ignores a halfword at offset 3.
  - LW: full word; low address bits are ignored, with no misaligned flag (matches the store side).
- Unknown funct3 under `OPC_LOAD`: result 0, load_valid still 1, misaligned 0.
- FSM:
  - IDLE: no pending load.
  - RESP: pending load; output is the live formatted memory data.
  - HELD: output comes from the hold register.
- FSM transitions:
  - IDLE → RESP on acceptance.
  - RESP → RESP on a new acceptance (back-to-back loads).
  - RESP → IDLE when stall = 0 and there is no new load.
  - RESP → HELD when stall = 1; the formatted result is latched into the hold register.
  - HELD stays in HELD while stall = 1.
  - HELD → IDLE on stall = 0, or → RESP on stall = 0 with a new load accepted that cycle.
- Non-load instructions never change the captured fields except through these FSM rules.

## Timing
- Reset values: state IDLE, load_valid 0, data_out 0, misaligned 0, hold register 0, captured fields 0.
- Latency is 1 cycle: a load accepted at edge N gives load_valid = 1 during cycle N+1, with data_out derived combinationally from the *_dout inputs.
- In IDLE: load_valid 0 and data_out 0.
- In HELD: data_out and misaligned equal the values latched at the RESP→HELD edge, regardless of *_dout changes.
- Throughput is one load per cycle when stall = 0.
- A load presented while stall = 1 is not accepted; upstream must re-present it.
- rst has priority over everything, including mid-stall; the next cycle is IDLE with outputs at reset values.

## Structure
- Load funct3 and opcode constants come from the shared `Opcode.vh`.
- Region encoding (NONE/DMEM/BIOS/IO) and FSM state encodings go in a shared header, `MemMap.vh`, reused by the store controller's region decode.
- One combinational sub-module, `load_extract`: inputs funct3, offset and a 32-bit word; outputs the 32-bit result and the misaligned flag.
- The FSM, capture registers, region mux and hold register stay in the top module.

## Test plan
- LB at 0x1000_0003, dmem_dout = 0x80AB_CDEF, stall 0 → next cycle load_valid = 1, data_out = 0xFFFF_FF80; LBU on the same inputs → 0x0000_0080.
- LH at 0x1000_0002, dmem_dout = 0x8001_1234 → data_out = 0xFFFF_8001. LHU at offset 3 → data_out = 0, misaligned = 1. LW at 0x1000_0001 → data_out = 0x8001_1234, misaligned = 0.
- Region priority: LW at 0xC000_0000 with io_dout = 0x1111_1111 and bios_dout = 0x2222_2222 → 0x1111_1111. LW at 0x0000_0000 → 0.
- Back-to-back LW, LB, LHU at consecutive cycles → three consecutive load_valid pulses with correct formatting; no bubble.
- LW accepted, then stall = 1 for 3 cycles while dmem_dout changes each cycle → data_out stays at the first-cycle value for all stalled cycles. A load presented during the stall is not accepted. After the stall drops with no load, load_valid = 0 next cycle.
- rst asserted in HELD → next cycle load_valid = 0, data_out = 0, misaligned = 0; a subsequent load behaves normally.

Source files
------------

// File: rtl/mem_read_controller_pkg.sv
// Shared load-path constants: opcode/funct3 encodings, memory regions, FSM states.
package mem_read_controller_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_DMEM = 2'd1,
    REG_BIOS = 2'd2,
    REG_IO   = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  // Region decode, highest address bit wins: IO > BIOS > DMEM > NONE.
  function automatic region_e decode_region(input logic [31:0] addr);
    if (addr[31])      return REG_IO;
    else if (addr[30]) return REG_BIOS;
    else if (addr[28]) return REG_DMEM;
    else               return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_read_controller_load_extract.sv
// Combinational load formatter: picks byte/halfword/word at the given offset
// and sign- or zero-extends it. Halfwords at offset 3 straddle the word and
// are suppressed with a misaligned flag, mirroring the store side.
module load_extract
  import mem_read_controller_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend by access size.
  always_comb begin
    shifted      = word_i >> {offset_i, 3'b000};
    result_o     = 32'd0;
    misaligned_o = 1'b0;
    case (funct3_i)
      FNC_LB:  result_o = {{24{shifted[7]}}, shifted[7:0]};
      FNC_LBU: result_o = {24'd0, shifted[7:0]};
      FNC_LH: begin
        if (offset_i == 2'd3) misaligned_o = 1'b1;
        else                  result_o = {{16{shifted[15]}}, shifted[15:0]};
      end
      FNC_LHU: begin
        if (offset_i == 2'd3) misaligned_o = 1'b1;
        else                  result_o = {16'd0, shifted[15:0]};
      end
      FNC_LW:  result_o = word_i;
      default: result_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_read_controller.sv
// Load-side memory controller: accepts loads in execute, selects the region,
// formats the synchronous-read data one cycle later and holds it across stalls.
module mem_read_controller
  import mem_read_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] address,
  input  logic        stall,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] bios_dout,
  input  logic [31:0] io_dout,
  output logic        load_valid,
  output logic [31:0] data_out,
  output logic        misaligned
);

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  region_e     region_q;
  logic        valid_q;
  logic [31:0] hold_data_q;
  logic        hold_mis_q;

  logic        accept;
  region_e     region_d;
  logic [31:0] word_sel;
  logic [31:0] ext_data;
  logic        ext_mis;

  // Only opcode, funct3 and the region/offset address bits matter here.
  logic unused_bits;
  assign unused_bits = ^{instruction[31:15], instruction[11:7], address[29], address[27:2]};

  assign accept   = (instruction[6:0] == OPC_LOAD) && !stall;
  assign region_d = decode_region(address);

  // Region mux on the data returned for the captured request; NONE reads as 0.
  always_comb begin
    word_sel = 32'd0;
    case (region_q)
      REG_DMEM: word_sel = dmem_dout;
      REG_BIOS: word_sel = bios_dout;
      REG_IO:   word_sel = io_dout;
      default:  word_sel = 32'd0;
    endcase
  end

  load_extract u_extract (
    .funct3_i     (funct3_q),
    .offset_i     (offset_q),
    .word_i       (word_sel),
    .result_o     (ext_data),
    .misaligned_o (ext_mis)
  );

  // Request FSM: capture on acceptance, latch the formatted result when a
  // stall arrives during the response cycle, release when the stall drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      funct3_q    <= 3'd0;
      offset_q    <= 2'd0;
      region_q    <= REG_NONE;
      valid_q     <= 1'b0;
      hold_data_q <= 32'd0;
      hold_mis_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            funct3_q <= instruction[14:12];
            offset_q <= address[1:0];
            region_q <= region_d;
            valid_q  <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (accept) begin
            funct3_q <= instruction[14:12];
            offset_q <= address[1:0];
            region_q <= region_d;
            valid_q  <= 1'b1;
            state_q  <= ST_RESP;
          end else if (stall) begin
            hold_data_q <= ext_data;
            hold_mis_q  <= ext_mis;
            valid_q     <= 1'b1;
            state_q     <= ST_HELD;
          end else begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_HELD: begin
          if (stall) begin
            state_q <= ST_HELD;
          end else if (accept) begin
            funct3_q <= instruction[14:12];
            offset_q <= address[1:0];
            region_q <= region_d;
            valid_q  <= 1'b1;
            state_q  <= ST_RESP;
          end else begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output select: live formatted data in RESP, hold register in HELD, 0 idle.
  always_comb begin
    data_out   = 32'd0;
    misaligned = 1'b0;
    case (state_q)
      ST_RESP: begin
        data_out   = ext_data;
        misaligned = ext_mis;
      end
      ST_HELD: begin
        data_out   = hold_data_q;
        misaligned = hold_mis_q;
      end
      default: begin
        data_out   = 32'd0;
        misaligned = 1'b0;
      end
    endcase
  end

  assign load_valid = valid_q;

endmodule

// File: tb/tb_mem_read_controller.sv
// Self-checking bench for mem_read_controller: table of load vectors streamed
// back-to-back through a scoreboard, plus stall, held-restart and reset sequences.
module tb_mem_read_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0000_0013;
  logic [31:0] address = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] dmem_dout = 32'd0;
  logic [31:0] bios_dout = 32'd0;
  logic [31:0] io_dout = 32'd0;
  logic        load_valid;
  logic [31:0] data_out;
  logic        misaligned;

  mem_read_controller dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .address     (address),
    .stall       (stall),
    .dmem_dout   (dmem_dout),
    .bios_dout   (bios_dout),
    .io_dout     (io_dout),
    .load_valid  (load_valid),
    .data_out    (data_out),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] dmem;
    logic [31:0] bios;
    logic [31:0] io;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] ld(input logic [2:0] f3);
    return {17'd0, f3, 5'd1, 7'b0000011};
  endfunction

  function automatic vec_t mk(input string n, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] dm, input logic [31:0] bi, input logic [31:0] io_,
                              input logic [31:0] ed, input logic em);
    vec_t v;
    v.name = n; v.f3 = f3; v.addr = a; v.dmem = dm; v.bios = bi; v.io = io_;
    v.exp_data = ed; v.exp_mis = em;
    return v;
  endfunction

  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are then settled.
  task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] adr,
                       input logic [31:0] dm, input logic [31:0] bi, input logic [31:0] io_,
                       input logic st);
    @(negedge clk);
    rst = r; instruction = ins; address = adr;
    dmem_dout = dm; bios_dout = bi; io_dout = io_; stall = st;
    #1;
  endtask

  // Compare current outputs against the oldest outstanding expectation, or
  // against an idle output when nothing is outstanding.
  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      chk1("idle_valid", load_valid, 1'b0);
      chk32("idle_data", data_out, 32'd0);
    end else begin
      e = sb.pop_front();
      chk1({e.name, "_valid"}, load_valid, 1'b1);
      chk32({e.name, "_data"}, data_out, e.data);
      chk1({e.name, "_mis"}, misaligned, e.mis);
    end
  endtask

  task automatic push(input string n, input logic [31:0] d, input logic m);
    exp_t e;
    e.name = n; e.data = d; e.mis = m;
    sb.push_back(e);
  endtask

  initial begin
    vecs.push_back(mk("lb_off3",   3'b000, 32'h1000_0003, 32'h80AB_CDEF, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0));
    vecs.push_back(mk("lbu_off3",  3'b100, 32'h1000_0003, 32'h80AB_CDEF, 32'h0, 32'h0, 32'h0000_0080, 1'b0));
    vecs.push_back(mk("lh_off2",   3'b001, 32'h1000_0002, 32'h8001_1234, 32'h0, 32'h0, 32'hFFFF_8001, 1'b0));
    vecs.push_back(mk("lhu_off3",  3'b101, 32'h1000_0003, 32'h8001_1234, 32'h0, 32'h0, 32'h0000_0000, 1'b1));
    vecs.push_back(mk("lw_off1",   3'b010, 32'h1000_0001, 32'h8001_1234, 32'h0, 32'h0, 32'h8001_1234, 1'b0));
    vecs.push_back(mk("lw_io",     3'b010, 32'hC000_0000, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111, 1'b0));
    vecs.push_back(mk("lw_bios",   3'b010, 32'h5000_0000, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 1'b0));
    vecs.push_back(mk("lw_none",   3'b010, 32'h0000_0000, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000, 1'b0));
    vecs.push_back(mk("lh_off1",   3'b001, 32'h1000_0001, 32'h1234_5678, 32'h0, 32'h0, 32'h0000_3456, 1'b0));
    vecs.push_back(mk("lb_off0",   3'b000, 32'h1000_0000, 32'h1234_567F, 32'h0, 32'h0, 32'h0000_007F, 1'b0));
    vecs.push_back(mk("lhu_off0",  3'b101, 32'h1000_0000, 32'h0000_F00D, 32'h0, 32'h0, 32'h0000_F00D, 1'b0));
    vecs.push_back(mk("lbu_off1",  3'b100, 32'h1000_0001, 32'h0000_FE00, 32'h0, 32'h0, 32'h0000_00FE, 1'b0));
    vecs.push_back(mk("unk_f3",    3'b011, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0000, 1'b0));
    vecs.push_back(mk("lh_off3",   3'b001, 32'h1000_0003, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0000, 1'b1));

    // Reset state
    drive(1'b1, NOP, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, ld(3'b010), 32'h1000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    chk1("rst_valid", load_valid, 1'b0);
    chk32("rst_data", data_out, 32'd0);
    chk1("rst_mis", misaligned, 1'b0);

    // Table stream: load i presented while data for load i-1 returns
    for (int i = 0; i <= vecs.size(); i++) begin
      logic [31:0] ins, adr, dm, bi, io_;
      ins = NOP; adr = 32'd0; dm = 32'd0; bi = 32'd0; io_ = 32'd0;
      if (i < vecs.size()) begin
        ins = ld(vecs[i].f3);
        adr = vecs[i].addr;
      end
      if (i > 0) begin
        dm = vecs[i-1].dmem; bi = vecs[i-1].bios; io_ = vecs[i-1].io;
      end
      drive(1'b0, ins, adr, dm, bi, io_, 1'b0);
      check_sb();
      if (i < vecs.size()) push(vecs[i].name, vecs[i].exp_data, vecs[i].exp_mis);
    end
    drive(1'b0, NOP, 32'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
    check_sb();

    // Stall: response held over 3 stalled cycles while dmem changes
    drive(1'b0, ld(3'b010), 32'h1000_0000, 32'h0, 32'h0, 32'h0, 1'b0);
    check_sb();
    push("stall_first", 32'hAAAA_0001, 1'b0);
    drive(1'b0, NOP, 32'd0, 32'hAAAA_0001, 32'h0, 32'h0, 1'b1);
    check_sb();
    drive(1'b0, NOP, 32'd0, 32'h5555_0002, 32'h0, 32'h0, 1'b1);
    chk1("held1_valid", load_valid, 1'b1);
    chk32("held1_data", data_out, 32'hAAAA_0001);
    drive(1'b0, ld(3'b000), 32'h1000_0000, 32'h6666_0003, 32'h0, 32'h0, 1'b1);
    chk32("held2_data", data_out, 32'hAAAA_0001);
    drive(1'b0, NOP, 32'd0, 32'h7777_0004, 32'h0, 32'h0, 1'b0);
    chk1("held3_valid", load_valid, 1'b1);
    chk32("held3_data", data_out, 32'hAAAA_0001);
    drive(1'b0, NOP, 32'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
    chk1("after_stall_valid", load_valid, 1'b0);
    chk32("after_stall_data", data_out, 32'd0);

    // HELD -> RESP when the stall drops with a new load
    drive(1'b0, ld(3'b010), 32'h1000_0000, 32'h0, 32'h0, 32'h0, 1'b0);
    check_sb();
    push("pre_hold", 32'h0102_0304, 1'b0);
    drive(1'b0, NOP, 32'd0, 32'h0102_0304, 32'h0, 32'h0, 1'b1);
    check_sb();
    drive(1'b0, ld(3'b000), 32'h1000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    chk32("hold_restart_data", data_out, 32'h0102_0304);
    push("restart_lb", 32'hFFFF_FF80, 1'b0);
    drive(1'b0, NOP, 32'd0, 32'h0000_8000, 32'h0, 32'h0, 1'b0);
    check_sb();
    drive(1'b0, NOP, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    check_sb();

    // Reset while HELD with a misaligned result latched
    drive(1'b0, ld(3'b101), 32'h1000_0003, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, NOP, 32'd0, 32'h9999_9999, 32'h0, 32'h0, 1'b1);
    chk1("pre_rst_mis", misaligned, 1'b1);
    drive(1'b1, NOP, 32'd0, 32'h8888_8888, 32'h0, 32'h0, 1'b1);
    chk1("held_rst_mis", misaligned, 1'b1);
    drive(1'b0, ld(3'b010), 32'h1000_0000, 32'h7777_7777, 32'h0, 32'h0, 1'b0);
    chk1("post_rst_valid", load_valid, 1'b0);
    chk32("post_rst_data", data_out, 32'd0);
    chk1("post_rst_mis", misaligned, 1'b0);
    push("post_rst_lw", 32'hCAFE_BABE, 1'b0);
    drive(1'b0, NOP, 32'd0, 32'hCAFE_BABE, 32'h0, 32'h0, 1'b0);
    check_sb();
    drive(1'b0, NOP, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    check_sb();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
